rr_mux_reg: RTL and testbench
=============================

Name: rr_mux_reg

Overview:
- Parametrised N-input, WIDTH-bit round-robin arbitrated multiplexer with valid/ready handshakes and a registered output stage.
- Generalises the combinational 2:1/4:1 muxes: the select is generated internally by a fair arbiter instead of being an input.
- Sits between several producers (e.g. memory/IO requesters in the SLC datapath) and one shared consumer.
- Sustains one transfer per clock under continuous Out_ready.

Parameters:
- WIDTH, 16, data width per channel.
- N, 4, number of input channels; legal range 2..16, need not be a power of two.
- SELW, $clog2(N), derived width of channel index; not overridden.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- In_data  input  N*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- In_valid  input  N  per-channel request/valid.
- In_ready  output  N  per-channel accept; at most one bit set.
- Hold  input  1  lock grant on the channel transferring this cycle.
- Out_data  output  WIDTH  registered selected data.
- Out_valid  output  1  Out_data holds an untaken word.
- Out_src  output  SELW  channel index that produced Out_data.
- Out_ready  input  1  consumer accepts Out_data this cycle.

Behaviour:
- Reset (Reset_n=0, asynchronous, immediate): Out_valid=0, Out_data=0, Out_src=0, priority pointer ptr=0, In_ready=0.
- Register free: load_en = !Out_valid | Out_ready. This is a combinational path from Out_ready to In_ready, and it is permitted.
- Arbitration (combinational): scan channels ptr, ptr+1, …, N-1, 0, …, ptr-1. The grant g is the first channel with In_valid=1. If no channel is valid, there is no grant.
- In_ready[g] = load_en & grant_exists. All other In_ready bits are 0.
- Transfer on channel g when In_valid[g] & In_ready[g]. On the next edge: Out_data<=In_data[g], Out_src<=g, Out_valid<=1.
- Latency: exactly 1 cycle from input transfer to Out_valid.
- Pointer update, on an input transfer only:
  - Hold=0: ptr <= (g+1) mod N, wrapping N-1 -> 0 for any N.
  - Hold=1: ptr <= g, so the same channel keeps top priority.
  - No transfer: ptr unchanged, and Hold is ignored.
- Output drain: Out_valid & Out_ready with no input transfer the same cycle -> Out_valid<=0. Out_data and Out_src keep their last value; they are don't-care while Out_valid=0.
- Simultaneous drain and load: the register takes the new word with no bubble, and Out_valid stays 1.
- Stall: Out_valid=1 & Out_ready=0 -> Out_data, Out_src and Out_valid are held stable, all In_ready=0, ptr is frozen.
- Producer rules:
  - Once In_valid[k]=1, the producer holds In_valid[k] and its data until accepted.
  - In_valid must not depend on In_ready.
  - Deasserting valid before acceptance is a protocol violation. The block must not lock up; the arbiter simply re-evaluates.
- No combinational path from In_data to any output.
- Reset mid-operation: the buffered word is discarded, there is no partial output, and arbitration restarts at channel 0.

Test Plan:
- Reset: drive Reset_n=0 mid-stall with Out_valid=1 -> same cycle Out_valid=0, In_ready=0. After release, first grant to lowest valid channel ≥0.
- Single channel: N=4, only In_valid[2]=1 with data 16'hBEEF, Out_ready=1 -> In_ready=4'b0100. Next cycle Out_data=16'hBEEF, Out_src=2.
- Saturation: all In_valid=1, Out_ready=1 for 8 cycles -> Out_src sequence 0,1,2,3,0,1,2,3, Out_valid continuously 1, no bubbles.
- Backpressure: saturated, Out_ready=0 for 3 cycles -> Out_data/Out_src frozen, In_ready=0. On release the sequence resumes with no channel skipped or duplicated.
- Hold: all valid, Hold=1 while channel 1 transfers for 3 cycles -> Out_src 1,1,1. Drop Hold -> next grant 2.
- Non-power-of-two wrap: N=3, all valid -> Out_src 0,1,2,0,1. Out_src never equals 3.

Source files
------------

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-input round-robin arbitrated multiplexer with valid/ready
// handshakes and a single registered output stage.
//
// Ports:
//   Clk        rising-edge clock
//   Reset_n    asynchronous active-low reset
//   In_data    packed channel data, channel k at [k*WIDTH +: WIDTH]
//   In_valid   per-channel request
//   In_ready   per-channel accept, at most one bit set
//   Hold       keep top priority on the channel transferring this cycle
//   Out_data   registered selected data
//   Out_valid  Out_data holds an untaken word
//   Out_src    channel index that produced Out_data
//   Out_ready  consumer accepts Out_data this cycle
module rr_mux_reg #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [N*WIDTH-1:0] In_data,
    input  logic [N-1:0]       In_valid,
    output logic [N-1:0]       In_ready,
    input  logic               Hold,
    output logic [WIDTH-1:0]   Out_data,
    output logic               Out_valid,
    output logic [SELW-1:0]    Out_src,
    input  logic               Out_ready
);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  src_q;
    logic             valid_q;

    logic             load_en;
    logic             grant_valid;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;
    logic [SELW:0]    idx;
    logic [SELW-1:0]  cand;

    // Output register can take a new word when empty or being drained now.
    assign load_en = ~valid_q | Out_ready;

    // Scan ptr, ptr+1, ... modulo N; the first valid channel wins.
    // idx carries one extra bit so the wrap works for non-power-of-two N.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        cand        = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr_q} + (SELW + 1)'(i);
            if (idx >= (SELW + 1)'(N)) begin
                idx = idx - (SELW + 1)'(N);
            end
            cand = idx[SELW-1:0];
            if (!grant_valid && In_valid[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant == SELW'(k)) begin
                grant_data = In_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Reset_n gates the accept so no producer sees a handshake during reset.
    assign xfer     = grant_valid & load_en & Reset_n;
    assign In_ready = xfer ? (N'(1) << grant) : '0;

    always_comb begin
        if (Hold) begin
            ptr_d = grant;
        end else if (grant == SELW'(N - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant + SELW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else if (xfer) begin
            ptr_q   <= ptr_d;
            data_q  <= grant_data;
            src_q   <= grant;
            valid_q <= 1'b1;
        end else if (Out_ready) begin
            // Drain without reload; data/src keep their last value.
            valid_q <= 1'b0;
        end
    end

    assign Out_data  = data_q;
    assign Out_src   = src_q;
    assign Out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: drives an N=4 and an N=3 instance of rr_mux_reg with directed
// and randomized traffic and checks them against a behavioural model.
module tb_rr_mux_reg;

    logic clk = 1'b0;
    logic rst_n;

    logic [63:0] d0_in;
    logic [3:0]  d0_v, d0_r;
    logic        d0_hold, d0_ordy, d0_ov;
    logic [15:0] d0_od;
    logic [1:0]  d0_os;

    logic [47:0] d1_in;
    logic [2:0]  d1_v, d1_r;
    logic        d1_hold, d1_ordy, d1_ov;
    logic [15:0] d1_od;
    logic [1:0]  d1_os;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_mux_reg #(.WIDTH(16), .N(4)) dut0 (
        .Clk(clk), .Reset_n(rst_n), .In_data(d0_in), .In_valid(d0_v), .In_ready(d0_r),
        .Hold(d0_hold), .Out_data(d0_od), .Out_valid(d0_ov), .Out_src(d0_os),
        .Out_ready(d0_ordy)
    );

    rr_mux_reg #(.WIDTH(16), .N(3)) dut1 (
        .Clk(clk), .Reset_n(rst_n), .In_data(d1_in), .In_valid(d1_v), .In_ready(d1_r),
        .Hold(d1_hold), .Out_data(d1_od), .Out_valid(d1_ov), .Out_src(d1_os),
        .Out_ready(d1_ordy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: priority pointer plus a one-word output buffer.
    int          m_ptr   [2];
    bit          m_valid [2];
    logic [15:0] m_data  [2];
    int          m_src   [2];

    task automatic model_step(input int d, input int n, input logic [3:0] v,
                              input logic [63:0] dat, input logic [3:0] rdy,
                              input logic ov, input logic [15:0] od, input logic [1:0] os,
                              input logic ordy, input logic hld);
        int         g;
        logic [3:0] exp_rdy;
        if (!rst_n) begin
            m_ptr[d]   = 0;
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_src[d]   = 0;
        end
        chk($sformatf("d%0d_out_valid", d), 64'(ov), 64'(m_valid[d]));
        chk($sformatf("d%0d_out_data", d), 64'(od), 64'(m_data[d]));
        chk($sformatf("d%0d_out_src", d), 64'(os), 64'(m_src[d]));

        g = -1;
        for (int i = 0; i < n; i++) begin
            if (g < 0 && v[(m_ptr[d] + i) % n]) g = (m_ptr[d] + i) % n;
        end
        exp_rdy = '0;
        if (rst_n && (!m_valid[d] || ordy) && g >= 0) exp_rdy = 4'(1) << g;
        chk($sformatf("d%0d_in_ready", d), 64'(rdy), 64'(exp_rdy));

        if (exp_rdy != '0) begin
            m_valid[d] = 1'b1;
            m_data[d]  = dat[g*16 +: 16];
            m_src[d]   = g;
            m_ptr[d]   = hld ? g : (g + 1) % n;
        end else if (rst_n && ordy) begin
            m_valid[d] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 4, d0_v, d0_in, d0_r, d0_ov, d0_od, d0_os, d0_ordy, d0_hold);
        model_step(1, 3, {1'b0, d1_v}, {16'h0, d1_in}, {1'b0, d1_r}, d1_ov, d1_od, d1_os,
                   d1_ordy, d1_hold);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         seq [8];
    logic [3:0] acc0;
    logic [2:0] acc1;

    initial begin
        rst_n   = 1'b0;
        d0_in   = '0; d0_v = '0; d0_hold = 1'b0; d0_ordy = 1'b0;
        d1_in   = '0; d1_v = '0; d1_hold = 1'b0; d1_ordy = 1'b0;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_out_valid", 64'(d0_ov), 64'(0));
        chk("rst_in_ready", 64'(d0_r), 64'(0));
        tick();
        rst_n = 1'b1;

        // Single channel
        d0_v = 4'b0100;
        d0_in[2*16 +: 16] = 16'hBEEF;
        d0_ordy = 1'b1;
        @(negedge clk);
        chk("single_in_ready", 64'(d0_r), 64'(4'b0100));
        tick();
        d0_v = '0;
        d0_ordy = 1'b0;
        @(negedge clk);
        chk("single_out_data", 64'(d0_od), 64'(16'hBEEF));
        chk("single_out_src", 64'(d0_os), 64'(2));

        // Stall, then reset mid-stall
        tick();
        for (int k = 0; k < 4; k++) d0_in[k*16 +: 16] = 16'h1000 + 16'(k);
        d0_v = 4'b1111;
        @(negedge clk);
        chk("stall_in_ready", 64'(d0_r), 64'(0));
        chk("stall_out_src", 64'(d0_os), 64'(2));
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(d0_ov), 64'(0));
        chk("midrst_in_ready", 64'(d0_r), 64'(0));
        tick();
        rst_n = 1'b1;
        d0_ordy = 1'b1;
        @(negedge clk);
        chk("first_grant", 64'(d0_r), 64'(4'b0001));

        // Saturation
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            seq[i] = int'(d0_os);
            chk("sat_valid", 64'(d0_ov), 64'(1));
        end
        for (int i = 0; i < 8; i++) chk($sformatf("sat_src%0d", i), 64'(seq[i]), 64'(i % 4));

        // Backpressure
        tick();
        d0_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_src_frozen", 64'(d0_os), 64'(0));
            chk("bp_data_frozen", 64'(d0_od), 64'(16'h1000));
            chk("bp_in_ready", 64'(d0_r), 64'(0));
            tick();
        end
        d0_ordy = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", 64'(d0_r), 64'(4'b0010));
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("bp_resume_src%0d", i), 64'(d0_os), 64'(i + 1));
        end

        // Hold on channel 1
        tick();
        d0_hold = 1'b1;
        tick();
        @(negedge clk);
        seq[0] = int'(d0_os);
        tick();
        d0_hold = 1'b0;
        @(negedge clk);
        seq[1] = int'(d0_os);
        tick();
        @(negedge clk);
        seq[2] = int'(d0_os);
        tick();
        @(negedge clk);
        seq[3] = int'(d0_os);
        chk("hold_src0", 64'(seq[0]), 64'(1));
        chk("hold_src1", 64'(seq[1]), 64'(1));
        chk("hold_src2", 64'(seq[2]), 64'(1));
        chk("hold_next", 64'(seq[3]), 64'(2));

        // Non-power-of-two wrap on the N=3 instance
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) d1_in[k*16 +: 16] = 16'h3000 + 16'(k);
        d1_v = 3'b111;
        d1_ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("n3_src%0d", i), 64'(d1_os), 64'(i % 3));
        end

        // Randomized traffic, occasional reset and valid withdrawal
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = d0_v & d0_r;
            acc1 = d1_v & d1_r;
            tick();
            rst_n = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < 4; k++) begin
                if (!d0_v[k] || acc0[k]) begin
                    d0_v[k] = ($urandom_range(0, 1) == 1);
                    d0_in[k*16 +: 16] = 16'($urandom);
                end else if ($urandom_range(0, 99) == 0) begin
                    d0_v[k] = 1'b0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (!d1_v[k] || acc1[k]) begin
                    d1_v[k] = ($urandom_range(0, 1) == 1);
                    d1_in[k*16 +: 16] = 16'($urandom);
                end else if ($urandom_range(0, 99) == 0) begin
                    d1_v[k] = 1'b0;
                end
            end
            d0_ordy = ($urandom_range(0, 3) != 0);
            d1_ordy = ($urandom_range(0, 3) != 0);
            d0_hold = ($urandom_range(0, 3) == 0);
            d1_hold = ($urandom_range(0, 3) == 0);
        end

        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
